mem_access: RTL and testbench

- MEM stage of the 5-stage pipeline: consumes the ex_mem register outputs (EX result, destination register, memory-op code, store data) and produces the operands for mem_wb.
- Non-memory ops pass through in one cycle.
- Loads and stores run serially, one byte at a time, over the 8-bit synchronous RAM port.
- stall_req holds the front of the pipeline until the access finishes.

---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/mem_access_load_ext.sv | 26 ++
 rtl/mem_access.sv | 144 ++++++++++++++
 tb/tb_mem_access.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_access_pkg;

  localparam int REG_LEN      = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int MEM_OP_LEN   = 4;
  localparam logic [REG_LEN-1:0] ZERO_WORD = '0;

  typedef enum logic [MEM_OP_LEN-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  // Request fields latched when an access starts.
  typedef struct packed {
    mem_op_e                 op;
    logic [REG_ADDR_LEN-1:0] rd_addr;
    logic                    rd_en;
  } mem_req_t;

  function automatic logic is_load(input mem_op_e op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  // Number of bytes moved by an access.
  function automatic logic [2:0] op_bytes(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
      default:                 return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load extender: assembles up to four little-endian bytes into a register
// value, sign-extending LB/LH and zero-extending LBU/LHU.
module mem_access_load_ext
  import mem_access_pkg::*;
#(
  parameter int XLEN = REG_LEN
) (
  input  logic [3:0][7:0]  bytes_i,
  input  mem_op_e          op_i,
  output logic [XLEN-1:0]  data_o
);

  // Pick width and extension from the op.
  always_comb begin
    data_o = '0;
    case (op_i)
      MEM_LB:  data_o = XLEN'($signed(bytes_i[0]));
      MEM_LH:  data_o = XLEN'($signed(bytes_i[1:0]));
      MEM_LBU: data_o = XLEN'(bytes_i[0]);
      MEM_LHU: data_o = XLEN'(bytes_i[1:0]);
      MEM_LW:  data_o = XLEN'(bytes_i);
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes non-memory results through in one cycle and runs loads
// and stores serially, one byte per cycle, over an 8-bit synchronous RAM.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int XLEN   = REG_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [XLEN-1:0]         rd_data_i,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
  input  logic                    rd_enable_i,
  input  logic [MEM_OP_LEN-1:0]   mem_op_i,
  input  logic [XLEN-1:0]         store_data_i,
  input  logic [7:0]              mem_din,
  output logic [ADDR_W-1:0]       mem_a,
  output logic [7:0]              mem_dout,
  output logic                    mem_wr,
  output logic [XLEN-1:0]         rd_data_o,
  output logic [REG_ADDR_LEN-1:0] rd_addr_o,
  output logic                    rd_enable_o,
  output logic                    stall_req
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e          state_q;
  logic [2:0]      cnt_q;
  mem_req_t        req_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] sdata_q;
  logic [3:0][7:0] byte_q;

  mem_op_e         op_in;
  logic [2:0]      nbytes;
  logic            ld, st, done;
  logic [1:0]      lane;
  logic [ADDR_W-1:0] byte_addr;
  logic [3:0][7:0] asm_d;
  logic [XLEN-1:0] ld_data_d;

  assign op_in     = mem_op_e'(mem_op_i);
  assign nbytes    = op_bytes(req_q.op);
  assign ld        = is_load(req_q.op);
  assign st        = is_store(req_q.op);
  assign lane      = 2'(cnt_q - 3'd1);
  // Address arithmetic is mod 2^XLEN, then truncated to the RAM width.
  assign byte_addr = ADDR_W'(addr_q + XLEN'(cnt_q));

  // Byte gathered so far plus the one arriving on mem_din this cycle
  // (RAM data lags the address by one cycle, so cnt=k carries byte k-1).
  always_comb begin
    asm_d = byte_q;
    if (ld && cnt_q != 3'd0) asm_d[lane] = mem_din;
  end

  mem_access_load_ext #(.XLEN(XLEN)) u_ext (
    .bytes_i (asm_d),
    .op_i    (req_q.op),
    .data_o  (ld_data_d)
  );

  // RAM request, completion detect and stall; reset forces everything quiet.
  always_comb begin
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    stall_req = 1'b0;
    if (state_q == S_IDLE) begin
      stall_req = is_load(op_in) || is_store(op_in);
    end else begin
      if (cnt_q < nbytes) begin
        mem_a = byte_addr;
        if (st) begin
          mem_wr   = rdy;
          mem_dout = sdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
      end else begin
        mem_a = addr_q[ADDR_W-1:0];
      end
      done      = st ? (cnt_q == nbytes - 3'd1) : (cnt_q == nbytes);
      stall_req = !done;
    end
    if (!rst) begin
      mem_a     = '0;
      mem_dout  = '0;
      mem_wr    = 1'b0;
      stall_req = 1'b0;
    end
  end

  // Stage FSM: pass-through in IDLE, one byte per cycle in BUSY; frozen while rdy=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      byte_q      <= '0;
      rd_data_o   <= ZERO_WORD;
      rd_addr_o   <= '0;
      rd_enable_o <= 1'b0;
    end else if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (is_load(op_in) || is_store(op_in)) begin
            req_q       <= '{op: op_in, rd_addr: rd_addr_i, rd_en: rd_enable_i};
            addr_q      <= rd_data_i;
            sdata_q     <= store_data_i;
            byte_q      <= '0;
            cnt_q       <= '0;
            state_q     <= S_BUSY;
            rd_enable_o <= 1'b0;
          end else begin
            rd_data_o   <= rd_data_i;
            rd_addr_o   <= rd_addr_i;
            rd_enable_o <= rd_enable_i;
          end
        end
        default: begin
          if (ld && cnt_q != 3'd0) byte_q <= asm_d;
          if (done) begin
            state_q <= S_IDLE;
            if (ld) begin
              rd_data_o   <= ld_data_d;
              rd_addr_o   <= req_q.rd_addr;
              rd_enable_o <= req_q.rd_en;
            end else begin
              rd_enable_o <= 1'b0;
            end
          end else begin
            cnt_q       <= cnt_q + 3'd1;
            rd_enable_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte RAM model, write-strobe scoreboard and per-op
// result scoreboard.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int AW = 17;

  logic            clk, rst, rdy;
  logic [31:0]     rd_data_i, store_data_i;
  logic [4:0]      rd_addr_i;
  logic            rd_enable_i;
  logic [3:0]      mem_op_i;
  logic [7:0]      mem_din;
  logic [AW-1:0]   mem_a;
  logic [7:0]      mem_dout;
  logic            mem_wr;
  logic [31:0]     rd_data_o;
  logic [4:0]      rd_addr_o;
  logic            rd_enable_o;
  logic            stall_req;

  mem_access #(.ADDR_W(AW), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .mem_op_i(mem_op_i), .store_data_i(store_data_i), .mem_din(mem_din),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
    .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM, gated by rdy like the DUT.
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a] <= mem_dout;
      mem_din <= ram[mem_a];
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        en;
    logic        chk;
    int          lat;
  } exp_t;

  exp_t              exp_q[$];
  logic [AW+7:0]     wr_q[$];
  logic [AW-1:0]     a_trace[$];
  int                n_cmp = 0;
  int                n_fail = 0;

  // Every observed write strobe must match the next expected (addr, byte).
  always @(negedge clk) begin
    if (rst && mem_wr) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got a=%h d=%h, expected no write", mem_a, mem_dout);
      end else begin
        logic [AW+7:0] w;
        w = wr_q.pop_front();
        if ({mem_a, mem_dout} !== w) begin
          n_fail++;
          $display("FAIL wr_seq: got a=%h d=%h expected a=%h d=%h",
                   mem_a, mem_dout, w[AW+7:8], w[7:0]);
        end
      end
    end
  end

  function automatic int nb(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      default:          return 4;
    endcase
  endfunction

  task automatic idle();
    mem_op_i = MEM_NONE; rd_enable_i = 1'b0; rd_data_i = '0; rd_addr_i = '0;
  endtask

  // Issue one op at posedge+1; leaves inputs driven so a following call is
  // back-to-back. Returns at posedge+1 after the completion edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input logic en, input logic [31:0] xdata,
                       input int xlat, input int pause_at, input string nm);
    exp_t e;
    int cyc;
    logic s;
    logic [AW-1:0] ahold;
    logic is_st;
    is_st = (op >= 4'd6 && op <= 4'd8);
    e.data = xdata; e.addr = rd; e.en = is_st ? 1'b0 : en; e.chk = !is_st; e.lat = xlat;
    exp_q.push_back(e);
    if (is_st) begin
      for (int k = 0; k < nb(op); k++) begin
        logic [31:0] t;
        t = a + k;
        wr_q.push_back({t[AW-1:0], sd[8*k +: 8]});
      end
    end
    mem_op_i = op; rd_data_i = a; store_data_i = sd; rd_addr_i = rd; rd_enable_i = en;
    a_trace.delete();
    cyc = 0;
    forever begin
      @(negedge clk);
      s = stall_req;
      a_trace.push_back(mem_a);
      cyc++;
      @(posedge clk); #1;
      if (!s) break;
      if (cyc == pause_at) begin
        ahold = mem_a;
        rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_cmp++;
          if (mem_wr !== 1'b0 || mem_a !== ahold) begin
            n_fail++;
            $display("FAIL %s_pause: got wr=%b a=%h expected wr=0 a=%h", nm, mem_wr, mem_a, ahold);
          end
          @(posedge clk); #1;
        end
        rdy = 1'b1;
      end
      if (cyc > 20) begin
        n_cmp++; n_fail++;
        $display("FAIL %s_timeout: got no completion in %0d cycles, expected %0d", nm, cyc, xlat);
        break;
      end
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin
      n_fail++; $display("FAIL %s_lat: got %0d expected %0d", nm, cyc, e.lat);
    end
    n_cmp++;
    if (rd_enable_o !== e.en) begin
      n_fail++; $display("FAIL %s_en: got %b expected %b", nm, rd_enable_o, e.en);
    end
    if (e.chk) begin
      n_cmp++;
      if (rd_data_o !== e.data || rd_addr_o !== e.addr) begin
        n_fail++;
        $display("FAIL %s_data: got %h/%0d expected %h/%0d", nm, rd_data_o, rd_addr_o, e.data, e.addr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; store_data_i = '0; idle();
    mem_op_i = MEM_LW;
    #1;
    n_cmp++;
    if ({mem_wr, mem_a, mem_dout, stall_req, rd_data_o, rd_addr_o, rd_enable_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got wr=%b a=%h d=%h st=%b rd=%h/%h/%b expected all 0",
               mem_wr, mem_a, mem_dout, stall_req, rd_data_o, rd_addr_o, rd_enable_o);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (stall_req !== 1'b0 || rd_enable_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: got st=%b en=%b expected 0 0", stall_req, rd_enable_o);
    end
    idle();
    rst = 1'b1;
  endtask

  task automatic test_passthru();
    do_op(MEM_NONE, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h1234, 1, 0, "none");
    do_op(MEM_NONE, 32'hDEAD0001, 32'h0, 5'd31, 1'b0, 32'hDEAD0001, 1, 0, "none2");
  endtask

  task automatic test_preload();
    do_op(MEM_SB, 32'h7, 32'h0000_0080, 5'd0, 1'b0, 32'h0, 2, 0, "sb7");
    do_op(MEM_SW, 32'h100, 32'h1234_5678, 5'd0, 1'b0, 32'h0, 5, 0, "sw100");
    do_op(MEM_SW, 32'hFFFF_FFFE, 32'h4433_2211, 5'd0, 1'b0, 32'h0, 5, 0, "swwrap");
    do_op(MEM_SW, 32'h300, 32'h0, 5'd0, 1'b0, 32'h0, 5, 0, "sw300");
    idle();
  endtask

  task automatic test_lw();
    do_op(MEM_LW, 32'h100, 32'h0, 5'd9, 1'b1, 32'h1234_5678, 6, 0, "lw");
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] ea;
      ea = AW'(32'h100 + k);
      n_cmp++;
      if (a_trace[k+1] !== ea) begin
        n_fail++; $display("FAIL lw_addr%0d: got %h expected %h", k, a_trace[k+1], ea);
      end
    end
    idle();
  endtask

  task automatic test_lb();
    do_op(MEM_LB,  32'h7, 32'h0, 5'd3, 1'b1, 32'hFFFF_FF80, 3, 0, "lb");
    do_op(MEM_LBU, 32'h7, 32'h0, 5'd4, 1'b1, 32'h0000_0080, 3, 0, "lbu");
    idle();
  endtask

  task automatic test_sh();
    do_op(MEM_LW,  32'h100, 32'h0, 5'd1, 1'b1, 32'h1234_5678, 6, 0, "lw_pre");
    do_op(MEM_SH,  32'h201, 32'hAABB_CCDD, 5'd2, 1'b1, 32'h0, 3, 0, "sh");
    do_op(MEM_LHU, 32'h201, 32'h0, 5'd6, 1'b1, 32'h0000_CCDD, 4, 0, "lhu");
    idle();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ex [4];
    ex[0] = 17'h1FFFE; ex[1] = 17'h1FFFF; ex[2] = 17'h00000; ex[3] = 17'h00001;
    do_op(MEM_LW, 32'hFFFF_FFFE, 32'h0, 5'd7, 1'b1, 32'h4433_2211, 6, 0, "lwwrap");
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (a_trace[k+1] !== ex[k]) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %h expected %h", k, a_trace[k+1], ex[k]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    wr_q.push_back({17'h300, 8'h44});
    wr_q.push_back({17'h301, 8'h33});
    mem_op_i = MEM_SW; rd_data_i = 32'h300; store_data_i = 32'h1122_3344;
    rd_addr_i = 5'd8; rd_enable_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (mem_wr !== 1'b1 || mem_a !== 17'h302) begin
      n_fail++; $display("FAIL rstmid_pre: got wr=%b a=%h expected 1 302", mem_wr, mem_a);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_wr !== 1'b0 || stall_req !== 1'b0 || mem_a !== '0 || rd_data_o !== '0) begin
      n_fail++;
      $display("FAIL rstmid_drop: got wr=%b st=%b a=%h rd=%h expected 0 0 0 0",
               mem_wr, stall_req, mem_a, rd_data_o);
    end
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    do_op(MEM_NONE, 32'hCAFE, 32'h0, 5'd12, 1'b1, 32'hCAFE, 1, 0, "rstmid_none");
    do_op(MEM_LW, 32'h300, 32'h0, 5'd13, 1'b1, 32'h0000_3344, 6, 0, "rstmid_lw");
    idle();
  endtask

  task automatic test_rdy_pause();
    do_op(MEM_SH, 32'h401, 32'h0000_9234, 5'd0, 1'b0, 32'h0, 3, 0, "sh401");
    do_op(MEM_LH, 32'h401, 32'h0, 5'd14, 1'b1, 32'hFFFF_9234, 4, 0, "lh");
    do_op(MEM_LH, 32'h401, 32'h0, 5'd14, 1'b1, 32'hFFFF_9234, 4, 2, "lh_rdy");
    do_op(MEM_SW, 32'h410, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0, 5, 2, "sw_rdy");
    do_op(MEM_LW, 32'h410, 32'h0, 5'd15, 1'b1, 32'hDEAD_BEEF, 6, 0, "lw_rdy");
    idle();
  endtask

  task automatic test_back_to_back();
    do_op(MEM_SB,  32'h500, 32'h0000_00A5, 5'd0, 1'b0, 32'h0, 2, 0, "b2b_sb");
    do_op(MEM_LBU, 32'h500, 32'h0, 5'd16, 1'b1, 32'h0000_00A5, 3, 0, "b2b_lbu");
    do_op(MEM_LB,  32'h500, 32'h0, 5'd17, 1'b1, 32'hFFFF_FFA5, 3, 0, "b2b_lb");
    do_op(MEM_NONE, 32'h77, 32'h0, 5'd18, 1'b1, 32'h77, 1, 0, "b2b_none");
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, d;
      a = 32'h1000 + 32'(i) * 32'h40 + 32'($urandom_range(0, 7));
      d = $urandom;
      do_op(MEM_SW,  a, d, 5'd0, 1'b0, 32'h0, 5, 0, "rnd_sw");
      do_op(MEM_LW,  a, 32'h0, 5'd20, 1'b1, d, 6, 0, "rnd_lw");
      do_op(MEM_LHU, a + 1, 32'h0, 5'd21, 1'b1, {16'h0, d[23:8]}, 4, 0, "rnd_lhu");
      do_op(MEM_LB,  a + 3, 32'h0, 5'd22, 1'b1, {{24{d[31]}}, d[31:24]}, 3, 0, "rnd_lb");
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_preload();
    test_lw();
    test_lb();
    test_sh();
    test_wrap();
    test_reset_mid();
    test_rdy_pause();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_fail++; $display("FAIL wr_missing: got %0d writes outstanding expected 0", wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
